// File: rtl/slot_uart_pkg.sv
// Shared command code, FSM state type and synchronizer depth for the slot-card UART arbiter.
package slot_uart_pkg;

  localparam logic [15:0] CMD_UART_ARB_CFG = 16'h0041;
  localparam int          SYNC_DEPTH       = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_arb_select.sv
// Combinational requester pick: lowest requesting index at or after ptr, wrapping.
// A ptr held at zero degenerates to fixed lowest-index priority.
module uart_arb_select #(
  parameter int NUM_SLOTS = 4,
  parameter int PTR_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_SLOTS-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = (int'(ptr) + i) % NUM_SLOTS;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_slot_arbiter.sv
// Muxes one slot-card UART rx line onto the host (3 clk pin-to-pin) and routes host tx to a configured slot (1 clk).
// Define UART_ARB_RR_EN for round-robin selection; otherwise lowest index wins and no pointer exists.
module uart_slot_arbiter
  import slot_uart_pkg::*;
#(
  parameter int          NUM_SLOTS    = 4,
  parameter logic [15:0] IDLE_TIMEOUT = 16'd2000,
  parameter logic [7:0]  ARB_ADDR     = 8'h10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SLOTS-1:0] rx,
  output logic [NUM_SLOTS-1:0] tx,
  input  logic                 tx_slot,
  output logic                 rx_slot,
  input  logic [15:0]          spi_cmd_r,
  input  logic [7:0]           spi_addr_r,
  input  logic [39:0]          spi_data_r,
  input  logic                 spi_data_valid_r,
  output logic [NUM_SLOTS-1:0] grant,
  output logic                 busy
);

  localparam int          PTR_W   = $clog2(NUM_SLOTS);
  localparam logic [15:0] CNT_MAX = IDLE_TIMEOUT - 16'd1;

  arb_state_t           state_q, state_nxt;
  logic [NUM_SLOTS-1:0] sync_q [SYNC_DEPTH];
  logic [NUM_SLOTS-1:0] rx_sync, req, sel_gnt, en_mask_q, grant_nxt;
  logic [7:0]           tx_target_q;
  logic [15:0]          cnt_q, cnt_nxt;
  logic [PTR_W-1:0]     gidx_q, sel_idx, sel_ptr;
  logic                 rx_slot_nxt, cfg_wr, line_hi, mask_lost, timed_out;
  logic                 unused_spi;

  assign cfg_wr     = spi_data_valid_r && (spi_cmd_r == CMD_UART_ARB_CFG) && (spi_addr_r == ARB_ADDR);
  assign rx_sync    = sync_q[SYNC_DEPTH-1];
  assign req        = ~rx_sync & en_mask_q;
  assign line_hi    = rx_sync[gidx_q];
  assign mask_lost  = !en_mask_q[gidx_q];
  assign timed_out  = (cnt_q == CNT_MAX) && line_hi;
  assign unused_spi = ^spi_data_r;

`ifdef UART_ARB_RR_EN
  logic [PTR_W-1:0] ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr_q <= '0;
    else if (state_q == ST_RELEASE)
      ptr_q <= (gidx_q == PTR_W'(NUM_SLOTS - 1)) ? '0 : gidx_q + PTR_W'(1);
  end

  assign sel_ptr = ptr_q;
`else
  assign sel_ptr = '0;
`endif

  uart_arb_select #(
    .NUM_SLOTS(NUM_SLOTS),
    .PTR_W    (PTR_W)
  ) u_select (
    .req(req),
    .ptr(sel_ptr),
    .gnt(sel_gnt)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (sel_gnt[i]) sel_idx = PTR_W'(i);
  end

  // Synchronizers, config registers and tx routing run regardless of the rx grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < SYNC_DEPTH; d++) sync_q[d] <= '1;
      en_mask_q   <= '0;
      tx_target_q <= 8'hFF;
      tx          <= '1;
    end else begin
      sync_q[0] <= rx;
      for (int d = 1; d < SYNC_DEPTH; d++) sync_q[d] <= sync_q[d-1];
      if (cfg_wr) begin
        en_mask_q   <= spi_data_r[NUM_SLOTS-1:0];
        tx_target_q <= spi_data_r[15:8];
      end
      tx <= '1;
      if (tx_target_q < 8'(NUM_SLOTS)) tx[tx_target_q[PTR_W-1:0]] <= tx_slot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      rx_slot <= 1'b1;
      cnt_q   <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_nxt;
      grant   <= grant_nxt;
      busy    <= |grant_nxt;
      rx_slot <= rx_slot_nxt;
      cnt_q   <= cnt_nxt;
      if (state_q == ST_IDLE) gidx_q <= sel_idx;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (|req) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (mask_lost)      state_nxt = ST_IDLE;
        else if (timed_out) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from these next values so rx_slot never glitches low when no grant.
  always_comb begin
    grant_nxt   = '0;
    rx_slot_nxt = 1'b1;
    cnt_nxt     = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_nxt   = sel_gnt;
          rx_slot_nxt = rx_sync[sel_idx];
        end
      end
      ST_BUSY: begin
        if (state_nxt == ST_BUSY) begin
          grant_nxt   = grant;
          rx_slot_nxt = line_hi;
          if (!line_hi)
            cnt_nxt = '0;
          else if (cnt_q == CNT_MAX)
            cnt_nxt = cnt_q;
          else
            cnt_nxt = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_slot_arbiter.sv
// Self-checking bench for uart_slot_arbiter: directed vectors plus a randomized run against a behavioural model.
module tb_uart_slot_arbiter;

  localparam int N  = 4;
  localparam int TO = 2000;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] rx;
  logic [N-1:0] tx;
  logic         tx_slot;
  logic         rx_slot;
  logic [15:0]  spi_cmd_r;
  logic [7:0]   spi_addr_r;
  logic [39:0]  spi_data_r;
  logic         spi_data_valid_r;
  logic [N-1:0] grant;
  logic         busy;

  int checks = 0;
  int errors = 0;

  uart_slot_arbiter #(
    .NUM_SLOTS   (N),
    .IDLE_TIMEOUT(16'(TO)),
    .ARB_ADDR    (8'h10)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx              (rx),
    .tx              (tx),
    .tx_slot         (tx_slot),
    .rx_slot         (rx_slot),
    .spi_cmd_r       (spi_cmd_r),
    .spi_addr_r      (spi_addr_r),
    .spi_data_r      (spi_data_r),
    .spi_data_valid_r(spi_data_valid_r),
    .grant           (grant),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Behavioural reference: owner slot number, length of the current high run, delayed pin history.
  int           m_owner = -1;
  int           m_last  = 0;
  int           m_ptr   = 0;
  int           m_run   = 0;
  bit           m_rel   = 1'b0;
  logic [N-1:0] m_mask  = '0;
  logic [7:0]   m_tgt   = 8'hFF;
  logic [N-1:0] m_p1    = '1;
  logic [N-1:0] m_p2    = '1;
  logic [N-1:0] e_grant = '0;
  logic [N-1:0] e_tx    = '1;
  logic         e_busy  = 1'b0;
  logic         e_rxs   = 1'b1;

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_run = 0; m_rel = 1'b0;
    m_mask = '0; m_tgt = 8'hFF; m_p1 = '1; m_p2 = '1;
    e_grant = '0; e_tx = '1; e_busy = 1'b0; e_rxs = 1'b1;
  endtask

  task automatic model_edge();
    logic [N-1:0] rq;
    rq = ~m_p2 & m_mask;
    if (m_rel) begin
      m_rel = 1'b0;
`ifdef UART_ARB_RR_EN
      m_ptr = (m_last + 1) % N;
`endif
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++)
        if (m_owner < 0 && rq[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
      m_run = 0;
    end else if (!m_mask[m_owner]) begin
      m_owner = -1;
    end else if (m_p2[m_owner]) begin
      m_run++;
      if (m_run == TO) begin
        m_rel = 1'b1; m_last = m_owner; m_owner = -1;
      end
    end else begin
      m_run = 0;
    end
    e_rxs   = (m_owner >= 0) ? m_p2[m_owner] : 1'b1;
    e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e_busy  = (m_owner >= 0);
    e_tx    = '1;
    if (m_tgt < N) e_tx[m_tgt] = tx_slot;
    if (spi_data_valid_r && spi_cmd_r == 16'h0041 && spi_addr_r == 8'h10) begin
      m_mask = spi_data_r[N-1:0];
      m_tgt  = spi_data_r[15:8];
    end
    m_p2 = m_p1;
    m_p1 = rx;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_edge();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] mask, input logic [7:0] tgt);
    spi_cmd_r = 16'h0041; spi_addr_r = 8'h10;
    spi_data_r = {24'h0, tgt, 4'h0, mask};
    spi_data_valid_r = 1'b1;
    tick();
    spi_data_valid_r = 1'b0;
  endtask

  task automatic wait_grant(input bit want_idle, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((grant == '0) != want_idle) && n < limit);
  endtask

  typedef struct {
    logic         vld;
    logic [15:0]  cmd;
    logic [7:0]   addr;
    logic [39:0]  data;
    logic         txs;
    logic [N-1:0] exp_tx;
  } vec_t;

  vec_t         vecs [10];
  logic [9:0]   frame;
  logic [N-1:0] exp_g;
  int           n;

  initial begin
    vecs[0] = '{1'b1, 16'h0041, 8'h10, 40'h0205, 1'b0, 4'b1011};
    vecs[1] = '{1'b1, 16'h0041, 8'h10, 40'h0005, 1'b0, 4'b1110};
    vecs[2] = '{1'b1, 16'h0041, 8'h10, 40'h0305, 1'b0, 4'b0111};
    vecs[3] = '{1'b0, 16'h0041, 8'h10, 40'h0105, 1'b0, 4'b0111};
    vecs[4] = '{1'b1, 16'h0042, 8'h10, 40'h0105, 1'b0, 4'b0111};
    vecs[5] = '{1'b1, 16'h0041, 8'h11, 40'h0105, 1'b0, 4'b0111};
    vecs[6] = '{1'b1, 16'h0041, 8'h10, 40'h0705, 1'b0, 4'b1111};
    vecs[7] = '{1'b1, 16'h0041, 8'h10, 40'h0105, 1'b1, 4'b1111};
    vecs[8] = '{1'b1, 16'h0041, 8'h10, 40'h0105, 1'b0, 4'b1101};
    vecs[9] = '{1'b1, 16'h0041, 8'h10, 40'hFF05, 1'b0, 4'b1111};

    reset = 1'b1; rx = '1; tx_slot = 1'b1;
    spi_cmd_r = '0; spi_addr_r = '0; spi_data_r = '0; spi_data_valid_r = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_slot", rx_slot, 1);
    check("rst_tx", tx, 4'hF);

    // tx routing and config decode
    for (int i = 0; i < 10; i++) begin
      spi_cmd_r = vecs[i].cmd; spi_addr_r = vecs[i].addr; spi_data_r = vecs[i].data;
      spi_data_valid_r = vecs[i].vld; tx_slot = vecs[i].txs;
      tick();
      spi_data_valid_r = 1'b0;
      tick();
      check("tx_route", tx, vecs[i].exp_tx);
      check("rx_slot_idle", rx_slot, 1);
    end

    // slots 0 and 2 contend each round (mask is 0101 from the table)
    for (int r = 0; r < 4; r++) begin
      rx[0] = 1'b0; rx[2] = 1'b0;
      wait_grant(1'b0, 10, n);
`ifdef UART_ARB_RR_EN
      exp_g = (r % 2 == 1) ? 4'b0100 : 4'b0001;
`else
      exp_g = 4'b0001;
`endif
      check("arb_order", grant, exp_g);
      rx[0] = 1'b1; rx[2] = 1'b1;
      wait_grant(1'b1, TO + 20, n);
      tick(); tick();
    end

    // grant latency, rx mirroring, full duplex, idle release
    cfg(4'hF, 8'h00);
    tx_slot = 1'b0;
    rx[1] = 1'b0;
    tick(); tick();
    check("grant_early", grant, 0);
    tick();
    check("grant_3cyc", grant, 4'b0010);
    check("busy_on", busy, 1);
    check("rx_slot_start", rx_slot, 0);
    frame = 10'b0010011010;
    for (int k = 0; k < 10; k++) begin
      rx[1] = frame[k];
      tick();
      if (k >= 2) check("rx_mirror", rx_slot, frame[k-2]);
    end
    check("duplex_tx", tx, 4'b1110);
    rx[1] = 1'b1;
    wait_grant(1'b1, TO + 20, n);
    check("release_cycles", n, TO + 2);
    check("release_busy", busy, 0);
    check("release_rx_slot", rx_slot, 1);

    // mask cleared mid-frame
    tick(); tick();
    rx[1] = 1'b0;
    wait_grant(1'b0, 10, n);
    check("mid_grant", grant, 4'b0010);
    tick(); tick();
    check("mid_rx_low", rx_slot, 0);
    cfg(4'b1101, 8'h00);
    check("mask_hold", grant, 4'b0010);
    tick();
    check("mask_drop_grant", grant, 0);
    check("mask_drop_rx", rx_slot, 1);
    check("mask_drop_busy", busy, 0);
    rx[1] = 1'b1;
    repeat (3) tick();

    // reset in the middle of a frame
    cfg(4'hF, 8'h03);
    tx_slot = 1'b0;
    rx[3] = 1'b0;
    wait_grant(1'b0, 10, n);
    check("pre_rst_grant", grant, 4'b1000);
    check("pre_rst_tx", tx, 4'b0111);
    check("pre_rst_rx", rx_slot, 0);
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rx_slot", rx_slot, 1);
    check("mid_rst_tx", tx, 4'hF);
    #2;
    reset = 1'b0;
    repeat (4) tick();
    check("post_rst_mask", grant, 0);
    check("post_rst_tgt", tx, 4'hF);
    rx[3] = 1'b1;
    repeat (3) tick();

    // randomized traffic against the model
    cfg(4'hF, 8'h01);
    for (int c = 0; c < 12000; c++) begin
      for (int s = 0; s < N; s++) begin
        if (rx[s] == 1'b0) begin
          if ($urandom_range(2) == 0) rx[s] = 1'b1;
        end else if ($urandom_range(2999) == 0) begin
          rx[s] = 1'b0;
        end
      end
      tx_slot = 1'($urandom_range(1));
      if ($urandom_range(2499) == 0) begin
        spi_cmd_r  = ($urandom_range(7) == 0) ? 16'h0040 : 16'h0041;
        spi_addr_r = 8'h10;
        spi_data_r = {24'h0, 8'($urandom_range(9)), 4'h0, 4'($urandom_range(15))};
        spi_data_valid_r = 1'b1;
      end else begin
        spi_data_valid_r = 1'b0;
      end
      tick();
      check("rand_grant", grant, e_grant);
      check("rand_busy", busy, e_busy);
      check("rand_rx_slot", rx_slot, e_rxs);
      check("rand_tx", tx, e_tx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_slot_arbiter.md
UART_SLOT_ARBITER -- requirements
Module: uart_slot_arbiter

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of slot-card UART channels (2..8).
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 16'd2000, count of consecutive line-high clk cycles that ends a grant.
REQ-003 SHALL have parameter ARB_ADDR, default 8'h10, spi_addr_r value selecting this block.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx  input  NUM_SLOTS  slot-card UART lines into the arbiter; idle high.
REQ-007 tx  output  NUM_SLOTS  UART lines driven to the slot cards.
REQ-008 tx_slot  input  1  host MCU UART transmit line.
REQ-009 rx_slot  output  1  arbitrated UART line back to the host MCU.
REQ-010 spi_cmd_r, spi_addr_r, spi_data_r, spi_data_valid_r  input  16/8/40/1  registered SPI command bus.
REQ-011 grant  output  NUM_SLOTS  one-hot owner of rx_slot; all-zero when idle.
REQ-012 busy  output  1  high while any grant is held.

Function
REQ-013 A config write SHALL occur when spi_data_valid_r=1, spi_cmd_r=CMD_UART_ARB_CFG and spi_addr_r=ARB_ADDR; any other combination SHALL be ignored.
REQ-014 On a config write, en_mask SHALL load spi_data_r[NUM_SLOTS-1:0] and tx_target SHALL load spi_data_r[15:8], both taking effect the next cycle.
REQ-015 Each rx bit SHALL pass through a 2-flop synchronizer; a request SHALL be synced rx=0 AND en_mask bit=1.
REQ-016 FSM states SHALL be IDLE, BUSY and RELEASE.
REQ-017 IDLE: on any request, grant SHALL go one-hot to the chosen slot on the next edge and the FSM SHALL enter BUSY; with no request, the FSM SHALL stay in IDLE.
REQ-018 BUSY: rx_slot SHALL be registered from the granted slot's synced rx, giving 3 clk latency from rx pin to rx_slot.
REQ-019 BUSY: the idle counter SHALL clear on synced rx=0 and otherwise increment, saturating at IDLE_TIMEOUT-1.
REQ-020 BUSY: when the counter equals IDLE_TIMEOUT-1 with the line high, the FSM SHALL enter RELEASE.
REQ-021 RELEASE SHALL last one cycle, clear grant, update the round-robin pointer to granted index+1 mod NUM_SLOTS, and go to IDLE.
REQ-022 If the granted slot's en_mask bit clears during BUSY, the FSM SHALL enter IDLE on the next edge, with grant=0 and rx_slot=1.
REQ-023 rx_slot SHALL be 1 whenever grant=0.
REQ-024 tx[tx_target] SHALL equal tx_slot registered (1 clk); every other tx bit SHALL be 1; tx_target>=NUM_SLOTS SHALL drive all tx high.
REQ-025 tx routing SHALL be independent of the rx grant, so full duplex to different slots is allowed.
REQ-026 A request arriving in the same cycle as RELEASE SHALL be served in IDLE on the following cycle; none SHALL be lost.

Reset
REQ-027 On reset assertion: FSM=IDLE, grant=0, busy=0, rx_slot=1, tx=all 1, en_mask=0, tx_target=8'hFF, counter=0, round-robin pointer=0, synchronizers=1.
REQ-028 Reset asserted mid-frame SHALL abort immediately with no glitch low on rx_slot.

Configuration
REQ-029 With UART_ARB_RR_EN defined, selection SHALL be round-robin: the lowest requesting index at or after the pointer, wrapping.
REQ-030 Without UART_ARB_RR_EN, selection SHALL be fixed priority with the lowest index winning, and the pointer SHALL not be implemented.

Structure
REQ-031 CMD_UART_ARB_CFG (16'h0041), the FSM state enum and the synchronizer depth SHALL reside in shared package slot_uart_pkg.
REQ-032 The round-robin/priority selector SHALL be sub-module uart_arb_select: request and pointer in, one-hot grant out, combinational.

Verification
REQ-033 Reset, then write en_mask=4'b0101 and tx_target=2; drive tx_slot=0 -> tx=4'b1011 one cycle later; rx_slot stays 1.
REQ-034 en_mask=4'hF; pull rx[1] low -> grant=4'b0010 after 3 cycles; rx_slot mirrors rx[1] at 3-cycle lag; release after 2000 high cycles.
REQ-035 With UART_ARB_RR_EN, rx[0] and rx[2] go low together, repeated each grant -> grants alternate 0,2,0,2; without the macro -> slot 0 always wins.
REQ-036 Clear en_mask bit 1 while slot 1 is mid-frame -> grant=0 and rx_slot=1 next cycle.
REQ-037 Set tx_target=8'h07 -> tx=all 1 regardless of tx_slot.
REQ-038 Assert reset mid-frame -> all outputs at REQ-027 values in the same cycle.
